wb_master_port: RTL and testbench

WB_MASTER_PORT -- requirements
Module: wb_master_port

---
 rtl/wb_master_port.sv | 202 ++++++++++++++++++++
 tb/tb_wb_master_port.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_port.sv
// wb_master_port: single-outstanding Wishbone classic bus master.
// A requester hands over one command (valid/ready); the block runs it as a
// classic cyc/stb cycle, then presents one response (valid/ready).
// Optional feature macro: WBM_TIMEOUT_EN. When it is defined, a bus cycle
// that gets no ack for TIMEOUT_CYCLES cycles is aborted with rsp_err = 1.
// When it is undefined, the bus cycle waits for ack indefinitely.
module wb_master_port #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Elaboration-time guard: the timeout counter is 16 bits wide.
  if ((TIMEOUT_CYCLES == 32'd0) || (TIMEOUT_CYCLES > 32'd65535)) begin : g_bad_timeout
    $error("wb_master_port: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t      state_r;
  state_t      state_nxt_s;
  logic        take_s;
  logic        timeout_hit_s;

  logic        cyc_r;
  logic        stb_r;
  logic        we_r;
  logic [3:0]  sel_r;
  logic [31:0] adr_r;
  logic [31:0] dat_r;
  logic        rsp_valid_r;
  logic [31:0] rsp_dat_r;

  // Ready only while idle; reset forces it low even though state is IDLE.
  assign cmd_ready = (state_r == ST_IDLE) && !wb_rst_i;
  assign take_s    = cmd_valid && cmd_ready;

  assign wbm_cyc_o = cyc_r;
  assign wbm_stb_o = stb_r;
  assign wbm_we_o  = we_r;
  assign wbm_sel_o = sel_r;
  assign wbm_adr_o = adr_r;
  assign wbm_dat_o = dat_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_dat   = rsp_dat_r;

`ifdef WBM_TIMEOUT_EN
  // The abort fires on the cycle the count would reach TIMEOUT_CYCLES, so
  // exactly TIMEOUT_CYCLES bus cycles are allowed before cyc/stb drop.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  logic [15:0] tmo_cnt_r;
  logic        rsp_err_r;

  assign timeout_hit_s = (state_r == ST_BUS) && !wbm_ack_i && (tmo_cnt_r == TMO_LAST);
  assign rsp_err       = rsp_err_r;

  // Count bus cycles without ack; cleared when a new command is accepted.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tmo_cnt_r <= 16'd0;
    end else if (take_s) begin
      tmo_cnt_r <= 16'd0;
    end else if ((state_r == ST_BUS) && !wbm_ack_i && !timeout_hit_s) begin
      tmo_cnt_r <= tmo_cnt_r + 16'd1;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // Error flag: set on abort, cleared by a normal ack; ack wins a tie.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rsp_err_r <= 1'b0;
    end else if ((state_r == ST_BUS) && wbm_ack_i) begin
      rsp_err_r <= 1'b0;
    end else if (timeout_hit_s) begin
      rsp_err_r <= 1'b1;
    end else begin
      rsp_err_r <= rsp_err_r;
    end
  end
`else
  assign timeout_hit_s = 1'b0;
  assign rsp_err       = 1'b0;
`endif

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: one transaction at a time through IDLE -> BUS -> RESP.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (take_s) begin
          state_nxt_s = ST_BUS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (wbm_ack_i || timeout_hit_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_BUS;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Bus and response registers; command fields are only loaded on accept,
  // so they hold their last value through BUS, RESP and IDLE.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cyc_r       <= 1'b0;
      stb_r       <= 1'b0;
      we_r        <= 1'b0;
      sel_r       <= 4'h0;
      adr_r       <= 32'h0;
      dat_r       <= 32'h0;
      rsp_valid_r <= 1'b0;
      rsp_dat_r   <= 32'h0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (take_s) begin
            cyc_r <= 1'b1;
            stb_r <= 1'b1;
            we_r  <= cmd_we;
            sel_r <= cmd_sel;
            adr_r <= cmd_adr;
            dat_r <= cmd_dat;
          end
        end
        ST_BUS: begin
          if (wbm_ack_i) begin
            cyc_r       <= 1'b0;
            stb_r       <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_dat_r   <= we_r ? 32'h0 : wbm_dat_i;
          end else if (timeout_hit_s) begin
            cyc_r       <= 1'b0;
            stb_r       <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_dat_r   <= 32'h0;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
          end
        end
        default: begin
          cyc_r       <= 1'b0;
          stb_r       <= 1'b0;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_port.sv
// Bench for wb_master_port: table-driven directed transactions, hand-written
// multi-cycle sequences (reset, back-to-back, timeout, reset mid-cycle) and
// a randomized run against a transaction-level scoreboard.
module tb_wb_master_port;

  localparam int TMO = 4;
`ifdef WBM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  int checks = 0;
  int errors = 0;

  wb_master_port #(.TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_sel  (cmd_sel),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i),
    .wbm_dat_i(wbm_dat_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ack_dly;
    logic [31:0] sdat;
    int          stall;
    logic [31:0] exp_dat;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } cmd_t;

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } rsp_t;

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Present one command and wait (bounded) for it to be accepted.
  task automatic issue(input string tag, input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_ready"}, 96'(cmd_ready), 96'(1));
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    cmd_adr = $urandom(); cmd_dat = $urandom();
  endtask

  // Consume the pending response and check the port goes idle again.
  task automatic release_rsp(input string tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, "_rsp_gone"}, 96'(rsp_valid), 96'(0));
    chk({tag, "_ready_back"}, 96'(cmd_ready), 96'(1));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bit held;
    bit stable;
    issue(tag, v.we, v.adr, v.dat, v.sel);
    chk({tag, "_cyc_start"}, 96'({wbm_cyc_o, wbm_stb_o}), 96'(2'b11));
    held = 1'b1;
    for (int i = 0; i <= v.ack_dly; i++) begin
      if (!(wbm_cyc_o && wbm_stb_o && wbm_we_o === v.we && wbm_adr_o === v.adr &&
            wbm_sel_o === v.sel && wbm_dat_o === v.dat)) held = 1'b0;
      wbm_ack_i = (i == v.ack_dly);
      wbm_dat_i = (i == v.ack_dly) ? v.sdat : $urandom();
      step();
    end
    wbm_ack_i = 1'b0;
    chk({tag, "_bus_hold"}, 96'(held), 96'(1));
    chk({tag, "_cyc_end"}, 96'({wbm_cyc_o, wbm_stb_o}), 96'(2'b00));
    chk({tag, "_rsp"}, 96'({rsp_valid, rsp_err, rsp_dat}), 96'({1'b1, 1'b0, v.exp_dat}));
    if (v.stall > 0) begin
      stable = 1'b1;
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      for (int i = 0; i < v.stall; i++) begin
        step();
        if (!rsp_valid || rsp_dat !== v.exp_dat || rsp_err !== 1'b0 || wbm_cyc_o || cmd_ready)
          stable = 1'b0;
      end
      cmd_valid = 1'b0;
      chk({tag, "_stall_stable"}, 96'(stable), 96'(1));
    end
    release_rsp(tag);
  endtask

  vec_t vecs[5];
  cmd_t cq[$];
  rsp_t rq[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nrsp;
    bit ok;
    int bus_age;
    cmd_t c;

    wb_rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'h0;
    cmd_dat = 32'h0; cmd_sel = 4'h0; rsp_ready = 1'b0; wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;

    vecs[0] = '{1'b0, 32'h3000_0010, 32'h0000_0000, 4'hF, 2, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h3000_0004, 32'h0000_00A5, 4'h1, 1, 32'h1234_5678, 0, 32'h0000_0000};
    vecs[2] = '{1'b0, 32'h0000_0000, 32'h5555_AAAA, 4'h3, 0, 32'h0000_FFFF, 5, 32'h0000_FFFF};
    vecs[3] = '{1'b1, 32'hFFFF_FFFC, 32'hCAFE_F00D, 4'hC, 3, 32'h0000_1111, 2, 32'h0000_0000};
    vecs[4] = '{1'b0, 32'h8000_0000, 32'h0F0F_0F0F, 4'h5, 3, 32'hA5A5_5A5A, 1, 32'hA5A5_5A5A};

    // Reset state, with cmd_ready held low while reset is asserted.
    step();
    step();
    chk("rst_ready_low", 96'(cmd_ready), 96'(0));
    chk("rst_outputs", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_valid, rsp_err, rsp_dat},
        96'(0));
    wb_rst_i = 1'b0;
    step();
    chk("rst_release_ready", 96'(cmd_ready), 96'(1));

    // Directed table.
    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Ack outside a bus cycle is ignored.
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h7777_7777;
    step(); step();
    wbm_ack_i = 1'b0;
    chk("stray_ack_idle", 96'({wbm_cyc_o, rsp_valid, cmd_ready}), 96'(3'b001));

    // Back-to-back with zero-wait slave: 4 responses in 12 cycles.
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h0000_0100; cmd_dat = 32'h1; cmd_sel = 4'hF;
    rsp_ready = 1'b1;
    nrsp = 0; ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid) nrsp++;
      if (cmd_ready && (wbm_cyc_o || rsp_valid)) ok = 1'b0;
      wbm_ack_i = wbm_cyc_o;
      step();
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0; wbm_ack_i = 1'b0;
    chk("b2b_count", 96'(nrsp), 96'(4));
    chk("b2b_ready_only_idle", 96'(ok), 96'(1));
    chk("b2b_end_idle", 96'({cmd_ready, wbm_cyc_o}), 96'(2'b10));

    // Slave that never acks.
    issue("tmo", 1'b0, 32'h4000_0000, 32'h0, 4'hF);
    n = 0;
    while (wbm_cyc_o && n < 40) begin
      n++;
      wbm_ack_i = 1'b0;
      step();
    end
    if (TMO_EN) begin
      chk("tmo_bus_cycles", 96'(n), 96'(TMO));
      chk("tmo_rsp", 96'({rsp_valid, rsp_err, rsp_dat}), 96'({1'b1, 1'b1, 32'h0}));
    end else begin
      chk("notmo_still_waiting", 96'({wbm_cyc_o, rsp_valid}), 96'(2'b10));
      wbm_ack_i = 1'b1; wbm_dat_i = 32'h0BAD_F00D;
      step();
      wbm_ack_i = 1'b0;
      chk("notmo_rsp", 96'({rsp_valid, rsp_err, rsp_dat}), 96'({1'b1, 1'b0, 32'h0BAD_F00D}));
    end
    release_rsp("tmo");

    // Ack on the last allowed bus cycle wins over the timeout.
    issue("tmo_tie", 1'b0, 32'h4000_0004, 32'h0, 4'hF);
    for (int i = 0; i < TMO; i++) begin
      wbm_ack_i = (i == TMO - 1);
      wbm_dat_i = 32'h0BAD_F00D;
      step();
    end
    wbm_ack_i = 1'b0;
    chk("tmo_tie_rsp", 96'({wbm_cyc_o, rsp_valid, rsp_err, rsp_dat}), 96'({1'b0, 1'b1, 1'b0, 32'h0BAD_F00D}));
    release_rsp("tmo_tie");

    // One-cycle reset in the middle of a bus cycle.
    issue("rstbus", 1'b1, 32'h5000_0000, 32'h99, 4'h2);
    chk("rstbus_cyc", 96'(wbm_cyc_o), 96'(1));
    wb_rst_i = 1'b1;
    step();
    chk("rstbus_drop", 96'({wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready}), 96'(0));
    wb_rst_i = 1'b0;
    wbm_ack_i = 1'b1;
    step();
    wbm_ack_i = 1'b0;
    step();
    chk("rstbus_after", 96'({wbm_cyc_o, rsp_valid, cmd_ready}), 96'(3'b001));

    // Randomized traffic against a transaction-level scoreboard.
    bus_age = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_ready", 96'(cmd_ready), 96'(cq.size() == 0 && rq.size() == 0));
      chk("rnd_cyc", 96'({wbm_cyc_o, wbm_stb_o}), (cq.size() != 0) ? 96'(2'b11) : 96'(2'b00));
      chk("rnd_rsp_valid", 96'(rsp_valid), 96'(rq.size() != 0));
      if (cq.size() != 0 && wbm_cyc_o)
        chk("rnd_fields", 96'({wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}),
            96'({cq[0].we, cq[0].sel, cq[0].adr, cq[0].dat}));
      if (rq.size() != 0 && rsp_valid)
        chk("rnd_rsp", 96'({rsp_err, rsp_dat}), 96'({rq[0].err, rq[0].dat}));

      rsp_ready = ($urandom_range(0, 2) != 0);
      if (rsp_valid && rsp_ready && rq.size() != 0) void'(rq.pop_front());
      wbm_dat_i = $urandom();
      wbm_ack_i = 1'b0;
      if (wbm_cyc_o && cq.size() != 0) begin
        bus_age++;
        if ($urandom_range(0, 9) < 3) begin
          wbm_ack_i = 1'b1;
          rq.push_back('{dat: (cq[0].we ? 32'h0 : wbm_dat_i), err: 1'b0});
          void'(cq.pop_front());
        end else if (TMO_EN && bus_age == TMO) begin
          rq.push_back('{dat: 32'h0, err: 1'b1});
          void'(cq.pop_front());
        end
      end else begin
        wbm_ack_i = ($urandom_range(0, 3) == 0);
      end
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_we    = 1'($urandom_range(0, 1));
      cmd_adr   = $urandom();
      cmd_dat   = $urandom();
      cmd_sel   = 4'($urandom());
      if (cmd_ready && cmd_valid) begin
        c.we = cmd_we; c.adr = cmd_adr; c.dat = cmd_dat; c.sel = cmd_sel;
        cq.push_back(c);
        bus_age = 0;
      end
      step();
    end
    cmd_valid = 1'b0; wbm_ack_i = 1'b0; rsp_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
